// File: rtl/irda_rx_frame_checker.sv
// IrDA receive frame checker: parity/stop-bit checks, 1-deep valid/ready output
// register, saturating statistics and sticky status. Optional break detection: IRDA_BREAK_DET_EN.
module irda_rx_frame_checker #(
  parameter  int unsigned DATA_W      = 7,
  parameter  int unsigned PARITY_MODE = 1,
  parameter  int unsigned STOP_BITS   = 1,
  parameter  int unsigned CNT_W       = 8,
  localparam int unsigned FRAME_W     = DATA_W + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] in_frame,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_parity_err,
  output logic               out_framing_err,
  output logic               out_break,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_status,
  output logic               sticky_parity_err,
  output logic               sticky_framing_err,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   parity_err_cnt,
  output logic [CNT_W-1:0]   framing_err_cnt
);

  logic [DATA_W-1:0]    data_w;
  logic [STOP_BITS-1:0] stop_w;
  logic                 par_err, frm_err, brk;
  logic                 accept;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_perr_q, out_perr_d;
  logic              out_ferr_q, out_ferr_d;
  logic              out_brk_q, out_brk_d;
  logic              out_valid_q, out_valid_d;
  logic              sticky_perr_q, sticky_perr_d;
  logic              sticky_ferr_q, sticky_ferr_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  perr_cnt_q, perr_cnt_d;
  logic [CNT_W-1:0]  ferr_cnt_q, ferr_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    data_w  = in_frame[DATA_W-1:0];
    stop_w  = in_frame[FRAME_W-1 -: STOP_BITS];
    frm_err = ~&stop_w;
    case (PARITY_MODE)
      1:       par_err = ~(^data_w ^ in_frame[DATA_W]);
      2:       par_err = ^data_w ^ in_frame[DATA_W];
      default: par_err = 1'b0;
    endcase
`ifdef IRDA_BREAK_DET_EN
    brk = ~|in_frame;
`else
    brk = 1'b0;
`endif
    // A break frame is reported as such and never as a parity/framing error
    if (brk) begin
      par_err = 1'b0;
      frm_err = 1'b0;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    out_brk_d   = out_brk_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = data_w;
      out_perr_d  = par_err;
      out_ferr_d  = frm_err;
      out_brk_d   = brk;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear is applied first so an accept in the same cycle still counts and sets sticky bits
  always_comb begin
    frame_cnt_d   = clr_status ? '0 : frame_cnt_q;
    perr_cnt_d    = clr_status ? '0 : perr_cnt_q;
    ferr_cnt_d    = clr_status ? '0 : ferr_cnt_q;
    sticky_perr_d = clr_status ? 1'b0 : sticky_perr_q;
    sticky_ferr_d = clr_status ? 1'b0 : sticky_ferr_q;
    if (accept) begin
      frame_cnt_d = sat_inc(frame_cnt_d);
      if (par_err) begin
        perr_cnt_d    = sat_inc(perr_cnt_d);
        sticky_perr_d = 1'b1;
      end
      if (frm_err) begin
        ferr_cnt_d    = sat_inc(ferr_cnt_d);
        sticky_ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q    <= '0;
      out_perr_q    <= 1'b0;
      out_ferr_q    <= 1'b0;
      out_brk_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      sticky_perr_q <= 1'b0;
      sticky_ferr_q <= 1'b0;
      frame_cnt_q   <= '0;
      perr_cnt_q    <= '0;
      ferr_cnt_q    <= '0;
    end else begin
      out_data_q    <= out_data_d;
      out_perr_q    <= out_perr_d;
      out_ferr_q    <= out_ferr_d;
      out_brk_q     <= out_brk_d;
      out_valid_q   <= out_valid_d;
      sticky_perr_q <= sticky_perr_d;
      sticky_ferr_q <= sticky_ferr_d;
      frame_cnt_q   <= frame_cnt_d;
      perr_cnt_q    <= perr_cnt_d;
      ferr_cnt_q    <= ferr_cnt_d;
    end
  end

  assign out_data           = out_data_q;
  assign out_parity_err     = out_perr_q;
  assign out_framing_err    = out_ferr_q;
  assign out_break          = out_brk_q;
  assign out_valid          = out_valid_q;
  assign sticky_parity_err  = sticky_perr_q;
  assign sticky_framing_err = sticky_ferr_q;
  assign frame_cnt          = frame_cnt_q;
  assign parity_err_cnt     = perr_cnt_q;
  assign framing_err_cnt    = ferr_cnt_q;

endmodule
